sample_decimator: RTL and testbench

Cascaded-integrator-comb (CIC) decimator that takes a high-rate 16-bit audio stream with a per-sample valid strobe and emits one gain-normalized 16-bit sample every 2^DECIM_LOG2 accepted inputs, with a single-cycle output valid. It is the inverse path to the resample-then-upsample chain: it brings an upsampled, oversampled stream (e.g. an effects or monitoring tap) back down to the base sample rate. Its output feeds any consumer with a `sample_in`/`sample_in_valid` interface.

---
 rtl/sample_decimator_pkg.sv | 14 +
 rtl/sample_decimator_cic_comb_stage.sv | 29 ++
 rtl/sample_decimator.sv | 109 ++++++++++
 tb/tb_sample_decimator.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_decimator_pkg.sv
// rtl/sample_decimator_pkg.sv - shared audio types, limits and CIC width helper
package sample_decimator_pkg;

  typedef logic signed [15:0] sample_t;

  localparam sample_t SAMPLE_MAX = 16'sh7fff;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  // Bit growth of an ORDER-stage CIC at ratio 2^decim_log2 is order*decim_log2 bits
  function automatic int cic_acc_width(input int order, input int decim_log2);
    return 16 + order * decim_log2;
  endfunction

endpackage

// File: rtl/sample_decimator_cic_comb_stage.sv
// rtl/sample_decimator_cic_comb_stage.sv - one token-gated CIC comb stage (x - x_prev)
module cic_comb_stage #(
  parameter int ACC_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] data_in,
  input  logic             tok_in,
  output logic [ACC_W-1:0] data_out,
  output logic             tok_out
);

  logic [ACC_W-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      data_out <= '0;
      tok_out  <= 1'b0;
    end else begin
      tok_out <= tok_in;
      if (tok_in) begin
        data_out <= data_in - prev;
        prev     <= data_in;
      end
    end
  end

endmodule

// File: rtl/sample_decimator.sv
// rtl/sample_decimator.sv - CIC decimator by 2^DECIM_LOG2 with gain normalization and clamp
// SAMPLE_DECIMATOR_ROUND_EN selects round-half-up normalization instead of floor.
module sample_decimator
  import sample_decimator_pkg::*;
#(
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] sample_in,
  input  logic               sample_in_valid,
  output logic signed [15:0] sample_out,
  output logic               sample_out_valid
);

  localparam int ACC_W = cic_acc_width(ORDER, DECIM_LOG2);
  localparam int SHIFT = ORDER * DECIM_LOG2;

`ifdef SAMPLE_DECIMATOR_ROUND_EN
  localparam logic signed [ACC_W:0] ROUND_ADD = (ACC_W + 1)'(1) << (SHIFT - 1);
`else
  localparam logic signed [ACC_W:0] ROUND_ADD = '0;
`endif

  localparam logic signed [ACC_W:0] CLAMP_HI = (ACC_W + 1)'(SAMPLE_MAX);
  localparam logic signed [ACC_W:0] CLAMP_LO = (ACC_W + 1)'(SAMPLE_MIN);

  logic [ACC_W-1:0]      integ     [ORDER];
  logic [ACC_W-1:0]      integ_nxt [ORDER];
  logic [DECIM_LOG2-1:0] phase;
  logic                  dump_event;
  logic                  dump_pend;
  logic                  dump_tok;
  logic [ACC_W-1:0]      dump_reg;
  logic [ACC_W-1:0]      comb_data [ORDER+1];
  logic                  comb_tok  [ORDER+1];
  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;
  sample_t               clamped;

  // Chained integrators: stage i's new value is x plus the sum of old stages 0..i
  always_comb begin
    logic [ACC_W-1:0] run;
    run = {{(ACC_W-16){sample_in[15]}}, sample_in};
    for (int i = 0; i < ORDER; i++) begin
      run          = run + integ[i];
      integ_nxt[i] = run;
    end
  end

  assign dump_event = sample_in_valid && (phase == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ORDER; i++) integ[i] <= '0;
      phase     <= '0;
      dump_pend <= 1'b0;
      dump_tok  <= 1'b0;
      dump_reg  <= '0;
    end else begin
      if (sample_in_valid) begin
        for (int i = 0; i < ORDER; i++) integ[i] <= integ_nxt[i];
        phase <= phase + 1'b1;
      end
      // Capture one cycle after the dump event so latency is independent of input spacing
      dump_pend <= dump_event;
      dump_tok  <= dump_pend;
      if (dump_pend) dump_reg <= integ[ORDER-1];
    end
  end

  assign comb_data[0] = dump_reg;
  assign comb_tok[0]  = dump_tok;

  for (genvar j = 0; j < ORDER; j++) begin : g_comb
    cic_comb_stage #(
      .ACC_W (ACC_W)
    ) u_comb (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (comb_data[j]),
      .tok_in   (comb_tok[j]),
      .data_out (comb_data[j+1]),
      .tok_out  (comb_tok[j+1])
    );
  end

  // One guard bit so the rounding offset cannot wrap the top of the range
  assign biased  = $signed({comb_data[ORDER][ACC_W-1], comb_data[ORDER]}) + ROUND_ADD;
  assign shifted = biased >>> SHIFT;

  always_comb begin
    if (shifted > CLAMP_HI)      clamped = SAMPLE_MAX;
    else if (shifted < CLAMP_LO) clamped = SAMPLE_MIN;
    else                         clamped = shifted[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
    end else begin
      sample_out_valid <= comb_tok[ORDER];
      if (comb_tok[ORDER]) sample_out <= clamped;
    end
  end

endmodule

// File: tb/tb_sample_decimator.sv
// tb/tb_sample_decimator.sv - self-checking bench for sample_decimator against an FIR-equivalent model
module tb_sample_decimator;

  localparam int ORDER = 3;
  localparam int DL    = 4;
  localparam int R     = 1 << DL;
  localparam int SH    = ORDER * DL;
  localparam int HLEN  = ORDER * (R - 1) + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic signed [15:0] sample_out;
  logic               sample_out_valid;
  logic signed [15:0] in_data1 = '0;
  logic               in_valid1 = 1'b0;
  logic signed [15:0] sample_out1;
  logic               sample_out_valid1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hist[$];
  int exp_due[$];
  int exp_val[$];
  int last_out = 0;
  int h [HLEN];

  sample_decimator #(.ORDER(ORDER), .DECIM_LOG2(DL)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(in_data), .sample_in_valid(in_valid),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid)
  );

  sample_decimator #(.ORDER(1), .DECIM_LOG2(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_in(in_data1), .sample_in_valid(in_valid1),
    .sample_out(sample_out1), .sample_out_valid(sample_out_valid1)
  );

  always #5 clk = ~clk;

  // Impulse response of ORDER cascaded length-R boxcars
  task automatic build_h();
    int tmp [HLEN];
    int len = 1;
    h = '{default: 0};
    h[0] = 1;
    repeat (ORDER) begin
      tmp = '{default: 0};
      for (int a = 0; a < len; a++)
        for (int b = 0; b < R; b++) tmp[a+b] += h[a];
      len += R - 1;
      h = tmp;
    end
  endtask

  function automatic int cic_ref(input int n_end);
    longint acc = 0;
    for (int k = 0; k < HLEN; k++)
      if (n_end - k >= 0) acc += longint'(h[k]) * longint'(hist[n_end-k]);
`ifdef SAMPLE_DECIMATOR_ROUND_EN
    acc += longint'(1) << (SH - 1);
`endif
    acc = acc >>> SH;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_due.delete();
    exp_val.delete();
    last_out = 0;
  endtask

  // Drive one cycle from a negedge; the model accepts the input on the posedge
  task automatic step(input bit v, input logic signed [15:0] x);
    in_valid = v;
    in_data  = x;
    @(posedge clk);
    cyc++;
    if (rst_n && v) begin
      hist.push_back(int'(x));
      if (hist.size() % R == 0) begin
        exp_due.push_back(cyc + ORDER + 2);
        exp_val.push_back(cic_ref(hist.size() - 1));
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step(1'b0, '0);
    step(1'b0, '0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step(1'b0, '0);
    step(1'b1, 16'sd1234);
    checks += 2;
    if (sample_out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0b exp=0", sample_out_valid);
    end
    if (sample_out !== 16'sd0) begin
      failures++; $display("FAIL reset_data got=%0d exp=0", sample_out);
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_dc(input logic signed [15:0] level, input int spacing, input string name);
    int npulse = 0, prev_pc = 0, in_cnt = 0, edge_r = 0;
    bit exp_v, v;
    do_reset();
    for (int c = 0; c < 6 * R * spacing + ORDER + 3; c++) begin
      v = (c < 6 * R * spacing) && (c % spacing == 0);
      step(v, level);
      if (v) begin in_cnt++; if (in_cnt == R) edge_r = cyc; end
      exp_v = (exp_due.size() > 0 && exp_due[0] == cyc);
      if (exp_v) begin void'(exp_due.pop_front()); last_out = exp_val.pop_front(); end
      checks += 2;
      if (sample_out_valid !== exp_v) begin
        failures++; $display("FAIL %s_valid cyc=%0d got=%0b exp=%0b", name, cyc, sample_out_valid, exp_v);
      end
      if (sample_out !== 16'(last_out)) begin
        failures++; $display("FAIL %s_data cyc=%0d got=%0d exp=%0d", name, cyc, sample_out, last_out);
      end
      if (sample_out_valid) begin
        checks++;
        if (npulse == 0 && cyc != edge_r + ORDER + 2) begin
          failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, cyc, edge_r + ORDER + 2);
        end else if (npulse > 0 && cyc - prev_pc != R * spacing) begin
          failures++; $display("FAIL %s_period got=%0d exp=%0d", name, cyc - prev_pc, R * spacing);
        end
        if (npulse >= ORDER) begin
          checks++;
          if (sample_out !== level) begin
            failures++; $display("FAIL %s_settled got=%0d exp=%0d", name, sample_out, level);
          end
        end
        npulse++;
        prev_pc = cyc;
      end
    end
    checks++;
    if (npulse != 6) begin
      failures++; $display("FAIL %s_count got=%0d exp=6", name, npulse);
    end
  endtask

  task automatic test_alternating();
    bit exp_v;
    int settled;
`ifdef SAMPLE_DECIMATOR_ROUND_EN
    settled = 1;
`else
    settled = 0;
`endif
    do_reset();
    for (int c = 0; c < 6 * R + ORDER + 3; c++) begin
      step(c < 6 * R, 16'(c % 2));
      exp_v = (exp_due.size() > 0 && exp_due[0] == cyc);
      if (exp_v) begin void'(exp_due.pop_front()); last_out = exp_val.pop_front(); end
      checks += 2;
      if (sample_out_valid !== exp_v) begin
        failures++; $display("FAIL alt_valid cyc=%0d got=%0b exp=%0b", cyc, sample_out_valid, exp_v);
      end
      if (sample_out !== 16'(last_out)) begin
        failures++; $display("FAIL alt_data cyc=%0d got=%0d exp=%0d", cyc, sample_out, last_out);
      end
    end
    checks++;
    if (sample_out !== 16'(settled)) begin
      failures++; $display("FAIL alt_settled got=%0d exp=%0d", sample_out, settled);
    end
  endtask

  task automatic test_random();
    bit exp_v, v;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      v = (c < 480) && ($urandom_range(0, 3) != 0);
      step(v, 16'($urandom));
      exp_v = (exp_due.size() > 0 && exp_due[0] == cyc);
      if (exp_v) begin void'(exp_due.pop_front()); last_out = exp_val.pop_front(); end
      checks += 2;
      if (sample_out_valid !== exp_v) begin
        failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, sample_out_valid, exp_v);
      end
      if (sample_out !== 16'(last_out)) begin
        failures++; $display("FAIL rand_data cyc=%0d got=%0d exp=%0d", cyc, sample_out, last_out);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit exp_v;
    int npulse = 0, in_cnt = 0, edge_r = 0;
    do_reset();
    for (int c = 0; c < 2 * R + ORDER + 3; c++) step(c < 2 * R, 16'sd2000);
    for (int c = 0; c < 7; c++) step(1'b1, 16'sd2000);
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (sample_out !== 16'sd0) begin
      failures++; $display("FAIL midrst_data got=%0d exp=0", sample_out);
    end
    if (sample_out_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_valid got=%0b exp=0", sample_out_valid);
    end
    model_reset();
    @(negedge clk);
    step(1'b1, 16'sd2000);
    step(1'b1, 16'sd2000);
    rst_n = 1'b1;
    for (int c = 0; c < 2 * R + ORDER + 3; c++) begin
      step(c < R, 16'sd2000);
      if (c < R) begin in_cnt++; if (in_cnt == R) edge_r = cyc; end
      exp_v = (exp_due.size() > 0 && exp_due[0] == cyc);
      if (exp_v) begin void'(exp_due.pop_front()); last_out = exp_val.pop_front(); end
      checks += 2;
      if (sample_out_valid !== exp_v) begin
        failures++; $display("FAIL midrst_post_valid cyc=%0d got=%0b exp=%0b", cyc, sample_out_valid, exp_v);
      end
      if (sample_out !== 16'(last_out)) begin
        failures++; $display("FAIL midrst_post_data cyc=%0d got=%0d exp=%0d", cyc, sample_out, last_out);
      end
      if (sample_out_valid) begin
        npulse++;
        checks++;
        if (cyc != edge_r + ORDER + 2) begin
          failures++; $display("FAIL midrst_latency got=%0d exp=%0d", cyc, edge_r + ORDER + 2);
        end
      end
    end
    checks++;
    if (npulse != 1) begin
      failures++; $display("FAIL midrst_count got=%0d exp=1", npulse);
    end
  endtask

  task automatic test_order1_step();
    int q[$];
    int due[$];
    int val[$];
    int last1 = 0, y, seen50 = 0;
    bit exp_v;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      in_valid1 = (c < 12);
      in_data1  = (c < 5) ? 16'sd0 : 16'sd100;
      step(1'b0, '0);
      if (c < 12) begin
        q.push_back(int'(in_data1));
        if (q.size() % 2 == 0) begin
`ifdef SAMPLE_DECIMATOR_ROUND_EN
          y = (q[q.size()-2] + q[q.size()-1] + 1) >>> 1;
`else
          y = (q[q.size()-2] + q[q.size()-1]) >>> 1;
`endif
          due.push_back(cyc + 3);
          val.push_back(y);
        end
      end
      exp_v = (due.size() > 0 && due[0] == cyc);
      if (exp_v) begin void'(due.pop_front()); last1 = val.pop_front(); end
      checks += 2;
      if (sample_out_valid1 !== exp_v) begin
        failures++; $display("FAIL o1_valid cyc=%0d got=%0b exp=%0b", cyc, sample_out_valid1, exp_v);
      end
      if (sample_out1 !== 16'(last1)) begin
        failures++; $display("FAIL o1_data cyc=%0d got=%0d exp=%0d", cyc, sample_out1, last1);
      end
      if (sample_out_valid1 && sample_out1 == 16'sd50) seen50++;
    end
    in_valid1 = 1'b0;
    checks += 2;
    if (seen50 != 1) begin
      failures++; $display("FAIL o1_straddle got=%0d exp=1", seen50);
    end
    if (sample_out1 !== 16'sd100) begin
      failures++; $display("FAIL o1_final got=%0d exp=100", sample_out1);
    end
  endtask

  initial begin
    build_h();
    @(negedge clk);
    test_reset();
    test_dc(16'sd1000, 1, "dc1000");
    test_dc(-16'sd32768, 1, "dcmin");
    test_dc(16'sd32767, 1, "dcmax");
    test_dc(16'sd500, 3, "sparse500");
    test_alternating();
    test_random();
    test_mid_reset();
    test_order1_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
